// File: rtl/xctcmsg_pkg.sv
// Shared message types and arbitration definitions for the mailbox ingress path.
// Send and receive message layouts are kept bit-identical so loopback traffic can be re-labelled directly.
package xctcmsg_pkg;

   typedef struct packed {
      logic [7:0]  dst_id;
      logic [7:0]  src_id;
      logic [31:0] payload;
   } interface_send_data_t;

   typedef struct packed {
      logic [7:0]  dst_id;
      logic [7:0]  src_id;
      logic [31:0] payload;
   } interface_receive_data_t;

   typedef enum logic {
      ARB_SRC_LOOPBACK = 1'b0,
      ARB_SRC_NETWORK  = 1'b1
   } arb_src_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BURST_LB  = 2'd1,
      BURST_NET = 2'd2
   } arb_state_e;

   localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/ingress_output_reg.sv
// One-entry valid/ready register stage; load_i captures data_i/src_i at the next edge.
// Latency 1 cycle; loadable when empty or draining this cycle, so it sustains one message per cycle.
// Contents are held while valid_o=1 and ready_i=0.
module ingress_output_reg
   import xctcmsg_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    load_i,
   input  interface_receive_data_t data_i,
   input  logic                    src_i,
   input  logic                    ready_i,
   output logic                    loadable_o,
   output logic                    valid_o,
   output interface_receive_data_t data_o,
   output logic                    src_o
);

   logic                    r_valid;
   interface_receive_data_t r_data;
   logic                    r_src;

   assign loadable_o = !r_valid || ready_i;
   assign valid_o    = r_valid;
   assign data_o     = r_data;
   assign src_o      = r_src;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= 1'b0;
      end else if (load_i) begin
         r_valid <= 1'b1;
         r_data  <= data_i;
         r_src   <= src_i;
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mailbox_ingress_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the mailbox write port between loopback and network.
// Latency 1 cycle (registered output stage); readys are low whenever the output stage is stalled.
// Optional grant/stall counters are enabled with XCTCMSG_ARB_STATS_EN.
module mailbox_ingress_arbiter
   import xctcmsg_pkg::*;
#(
   parameter int MAX_BURST = ARB_MAX_BURST
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    loopback_valid_i,
   output logic                    loopback_ready_o,
   input  interface_send_data_t    loopback_data_i,
   input  logic                    network_valid_i,
   output logic                    network_ready_o,
   input  interface_receive_data_t network_data_i,
   output logic                    mailbox_valid_o,
   input  logic                    mailbox_ready_i,
   output interface_receive_data_t mailbox_data_o,
   output logic                    grant_src_o
`ifdef XCTCMSG_ARB_STATS_EN
   ,
   output logic [31:0]             stat_lb_grants_o,
   output logic [31:0]             stat_net_grants_o,
   output logic [31:0]             stat_stall_cycles_o
`endif
);

   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam logic [BURST_W-1:0] L_MAX = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] L_ONE = BURST_W'(1);

   arb_state_e              r_state, w_state_nxt;
   arb_src_e                r_last_src;
   logic [BURST_W-1:0]      r_cnt, w_cnt_nxt;
   logic                    w_loadable, w_arb_en;
   logic                    w_gnt_lb, w_gnt_net;
   interface_receive_data_t w_lb_data, w_load_data;

   // Grants are suppressed during reset so no ready leaks out while state is clearing.
   assign w_arb_en = rstn_i && w_loadable;

   always_comb begin
      w_gnt_lb    = 1'b0;
      w_gnt_net   = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_arb_en) begin
         unique case (r_state)
            IDLE: begin
               if (loopback_valid_i && (!network_valid_i || r_last_src == ARB_SRC_NETWORK))
                  w_gnt_lb = 1'b1;
               else if (network_valid_i)
                  w_gnt_net = 1'b1;
            end
            BURST_LB: begin
               if (loopback_valid_i && (!network_valid_i || r_cnt < L_MAX))
                  w_gnt_lb = 1'b1;
               else if (network_valid_i)
                  w_gnt_net = 1'b1;
            end
            BURST_NET: begin
               if (network_valid_i && (!loopback_valid_i || r_cnt < L_MAX))
                  w_gnt_net = 1'b1;
               else if (loopback_valid_i)
                  w_gnt_lb = 1'b1;
            end
            default: ;
         endcase
         // Staying with the same source extends the burst; any switch restarts it at 1.
         if (w_gnt_lb) begin
            w_state_nxt = BURST_LB;
            w_cnt_nxt   = (r_state != BURST_LB) ? L_ONE : (r_cnt == L_MAX) ? L_MAX : r_cnt + L_ONE;
         end else if (w_gnt_net) begin
            w_state_nxt = BURST_NET;
            w_cnt_nxt   = (r_state != BURST_NET) ? L_ONE : (r_cnt == L_MAX) ? L_MAX : r_cnt + L_ONE;
         end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_last_src <= ARB_SRC_NETWORK;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_gnt_lb || w_gnt_net)
            r_last_src <= w_gnt_net ? ARB_SRC_NETWORK : ARB_SRC_LOOPBACK;
      end
   end

   assign loopback_ready_o = w_gnt_lb;
   assign network_ready_o  = w_gnt_net;
   assign w_lb_data        = loopback_data_i;
   assign w_load_data      = w_gnt_net ? network_data_i : w_lb_data;

   ingress_output_reg u_out (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .load_i     (w_gnt_lb || w_gnt_net),
      .data_i     (w_load_data),
      .src_i      (w_gnt_net),
      .ready_i    (mailbox_ready_i),
      .loadable_o (w_loadable),
      .valid_o    (mailbox_valid_o),
      .data_o     (mailbox_data_o),
      .src_o      (grant_src_o)
   );

`ifdef XCTCMSG_ARB_STATS_EN
   logic [31:0] r_stat_lb, r_stat_net, r_stat_stall;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_stat_lb    <= '0;
         r_stat_net   <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_gnt_lb)
            r_stat_lb <= r_stat_lb + 32'd1;
         if (w_gnt_net)
            r_stat_net <= r_stat_net + 32'd1;
         if (mailbox_valid_o && !mailbox_ready_i)
            r_stat_stall <= r_stat_stall + 32'd1;
      end
   end

   assign stat_lb_grants_o    = r_stat_lb;
   assign stat_net_grants_o   = r_stat_net;
   assign stat_stall_cycles_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_mailbox_ingress_arbiter.sv
// Randomized and directed bench for mailbox_ingress_arbiter against a transaction-level fairness model.
module tb_mailbox_ingress_arbiter;
   import xctcmsg_pkg::*;

   localparam int MAXB = ARB_MAX_BURST;
   localparam int DW   = $bits(interface_receive_data_t);

   logic                    clk = 1'b0;
   logic                    rstn;
   logic                    lb_v, net_v, mb_rdy;
   interface_send_data_t    lb_d;
   interface_receive_data_t net_d;
   logic                    lb_r, net_r, mb_v, gsrc;
   interface_receive_data_t mb_d;
`ifdef XCTCMSG_ARB_STATS_EN
   logic [31:0]             s_lb, s_net, s_stall;
`endif

   mailbox_ingress_arbiter #(.MAX_BURST(MAXB)) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .loopback_valid_i (lb_v),
      .loopback_ready_o (lb_r),
      .loopback_data_i  (lb_d),
      .network_valid_i  (net_v),
      .network_ready_o  (net_r),
      .network_data_i   (net_d),
      .mailbox_valid_o  (mb_v),
      .mailbox_ready_i  (mb_rdy),
      .mailbox_data_o   (mb_d),
      .grant_src_o      (gsrc)
`ifdef XCTCMSG_ARB_STATS_EN
      ,
      .stat_lb_grants_o    (s_lb),
      .stat_net_grants_o   (s_net),
      .stat_stall_cycles_o (s_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: output stage contents plus a fairness record (who was served last, how many in a row).
   logic                    m_valid;
   interface_receive_data_t m_data;
   logic                    m_src;
   logic                    m_last;
   int                      m_streak;
   int                      m_lb_g, m_net_g, m_stall;
   logic                    e_lb, e_net;

   task automatic model_reset();
      m_valid  = 1'b0;
      m_data   = '0;
      m_src    = 1'b0;
      m_last   = 1'b1;
      m_streak = 0;
      m_lb_g   = 0;
      m_net_g  = 0;
      m_stall  = 0;
   endtask

   task automatic predict();
      logic pick_net;
      e_lb  = 1'b0;
      e_net = 1'b0;
      if (rstn && (!m_valid || mb_rdy)) begin
         if (lb_v && !net_v)
            e_lb = 1'b1;
         else if (net_v && !lb_v)
            e_net = 1'b1;
         else if (lb_v && net_v) begin
            // An ongoing run keeps the port until it reaches MAXB; otherwise the other side goes next.
            if (m_streak > 0 && m_streak < MAXB)
               pick_net = m_last;
            else
               pick_net = !m_last;
            e_net = pick_net;
            e_lb  = !pick_net;
         end
      end
   endtask

   task automatic advance();
      logic s;
      if (!rstn) begin
         model_reset();
         return;
      end
      if (m_valid && !mb_rdy)
         m_stall++;
      if (e_lb || e_net) begin
         s        = e_net;
         m_streak = (m_streak > 0 && s == m_last) ? m_streak + 1 : 1;
         m_last   = s;
         m_valid  = 1'b1;
         m_src    = s;
         m_data   = s ? net_d : lb_d;
         if (s) m_net_g++;
         else   m_lb_g++;
      end else if (!m_valid || mb_rdy) begin
         m_valid  = 1'b0;
         m_streak = 0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      predict();
      check_eq("lb_ready", lb_r, e_lb);
      check_eq("net_ready", net_r, e_net);
      check_eq("mb_valid", mb_v, m_valid);
      if (m_valid) begin
         check_eq("mb_data", mb_d, m_data);
         check_eq("grant_src", gsrc, m_src);
      end
      advance();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      lb_d = r[DW-1:0];
      r = {$urandom(), $urandom()};
      net_d = r[DW-1:0];
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   initial begin
      interface_receive_data_t held;
      interface_send_data_t    sent;
      rstn   = 1'b0;
      lb_v   = 1'b1;
      net_v  = 1'b1;
      mb_rdy = 1'b1;
      lb_d   = '0;
      net_d  = '0;
      model_reset();
      @(posedge clk);
      #1;
      step();
      check_eq("rst_data", mb_d, '0);
      check_eq("rst_src", gsrc, 1'b0);
`ifdef XCTCMSG_ARB_STATS_EN
      check_eq("rst_stat_lb", s_lb, 0);
      check_eq("rst_stat_stall", s_stall, 0);
`endif
      rstn = 1'b1;

      // Loopback alone: one grant per cycle, one-cycle latency.
      net_v = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rand_data();
         sent = lb_d;
         step();
         check_eq("lb_latency", mb_d, sent);
         check_eq("lb_src", gsrc, 1'b0);
      end
      lb_v = 1'b0;
      step();
      step();

      // Both requesting from reset: bursts of MAXB alternating, loopback first.
      do_reset();
      lb_v  = 1'b1;
      net_v = 1'b1;
      for (int k = 0; k < 12; k++) begin
         rand_data();
         step();
         check_eq("rr_seq", gsrc, ((k / MAXB) % 2 == 1) ? 1'b1 : 1'b0);
      end

      // Stall: stage contents must hold, then arbitration resumes.
      rand_data();
      step();
      mb_rdy = 1'b0;
      held   = mb_d;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         step();
      end
      check_eq("stall_hold", mb_d, held);
      mb_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rand_data();
         step();
      end

      // Network alone saturates its run; loopback then wins on the first contended cycle.
      do_reset();
      lb_v  = 1'b0;
      net_v = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_data();
         step();
      end
      lb_v = 1'b1;
      rand_data();
      step();
      check_eq("join_lb", gsrc, 1'b0);

      // Reset while the stage is full.
      mb_rdy = 1'b0;
      step();
      rstn = 1'b0;
      step();
      check_eq("rst_mid_valid", mb_v, 1'b0);
      rstn   = 1'b1;
      mb_rdy = 1'b1;
      rand_data();
      step();
      check_eq("rst_tie_lb", gsrc, 1'b0);

      // Counter scenario: 3 loopback grants, 2 network grants, 4 stalled cycles.
      do_reset();
      lb_v  = 1'b1;
      net_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         step();
      end
      lb_v  = 1'b0;
      net_v = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rand_data();
         step();
      end
      net_v  = 1'b0;
      mb_rdy = 1'b0;
      for (int i = 0; i < 4; i++) step();
`ifdef XCTCMSG_ARB_STATS_EN
      check_eq("stat_lb_3", s_lb, 3);
      check_eq("stat_net_2", s_net, 2);
      check_eq("stat_stall_4", s_stall, 4);
`endif
      mb_rdy = 1'b1;
      step();

      // Random traffic with dropping valids, backpressure and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         lb_v   = ($urandom_range(0, 3) != 0);
         net_v  = ($urandom_range(0, 3) != 0);
         mb_rdy = ($urandom_range(0, 3) != 0);
         rstn   = ($urandom_range(0, 299) != 0);
         rand_data();
         step();
      end
      rstn = 1'b1;
      step();
`ifdef XCTCMSG_ARB_STATS_EN
      check_eq("stat_lb_rand", s_lb, m_lb_g);
      check_eq("stat_net_rand", s_net, m_net_g);
      check_eq("stat_stall_rand", s_stall, m_stall);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
